irq_ctrl: RTL and testbench

Interrupt controller for the multi-interrupt CPU. Latches rising edges on four interrupt lines, applies a software mask and a global enable, and arbitrates by fixed priority with nesting. It raises a request to the control unit, hands over the winning 2-bit code on acknowledge, and tracks in-service levels until the matching return. The `out_code` output drives the interrupt-address decoder directly.

---
 rtl/irq_ctrl.sv | 75 +++++++
 tb/tb_irq_ctrl.sv | 199 +++++++++++++++++++
 2 files changed

// File: rtl/irq_ctrl.sv
// irq_ctrl: edge-latched, maskable, fixed-priority nesting interrupt controller for four sources
module irq_ctrl (
   input  logic       in_clk,
   input  logic       in_rst_n,
   input  logic [3:0] in_src,
   input  logic       in_ie,
   input  logic       in_mask_we,
   input  logic [3:0] in_mask,
   input  logic       in_ack,
   input  logic       in_eret,
   output logic       out_irq,
   output logic [1:0] out_code,
   output logic       out_code_valid,
   output logic [3:0] out_pending,
   output logic [3:0] out_inservice,
   output logic [3:0] out_mask
);
   typedef enum logic [1:0] {IDLE, REQ, VEC} state_t;
   state_t     r_state, w_next;
   logic [3:0] r_prev, r_pending, r_inservice, r_mask;
   logic [1:0] r_code;
   logic [3:0] w_edge, w_above, w_ins_hi, w_cand, w_elig, w_ack_oh;
   logic       w_ack;
   function automatic logic [1:0] f_enc(input logic [3:0] v);
      return v[3] ? 2'd3 : v[2] ? 2'd2 : v[1] ? 2'd1 : 2'd0;
   endfunction
   // Sources strictly above the highest level currently in service
   always_comb begin
      w_above  = r_inservice[3] ? 4'b0000 : r_inservice[2] ? 4'b1000 :
                 r_inservice[1] ? 4'b1100 : r_inservice[0] ? 4'b1110 : 4'b1111;
      w_ins_hi = r_inservice[3] ? 4'b1000 : r_inservice[2] ? 4'b0100 :
                 r_inservice[1] ? 4'b0010 : r_inservice[0] ? 4'b0001 : 4'b0000;
   end
   assign w_edge   = in_src & ~r_prev;
   assign w_cand   = r_pending & ~r_mask & w_above;
   assign w_elig   = in_ie ? w_cand : 4'b0000;
   assign w_ack    = (r_state == REQ) && in_ack;
   assign w_ack_oh = w_ack ? (4'b0001 << f_enc(w_elig)) : 4'b0000;
   always_ff @(posedge in_clk) begin
      if (!in_rst_n) begin
         r_prev      <= 4'b0000;
         r_pending   <= 4'b0000;
         r_inservice <= 4'b0000;
         r_mask      <= 4'hF;
         r_code      <= 2'b00;
      end else begin
         r_prev      <= in_src;
         r_pending   <= (r_pending & ~w_ack_oh) | w_edge;
         r_inservice <= (r_inservice & ~(in_eret ? w_ins_hi : 4'b0000)) | w_ack_oh;
         if (in_mask_we) r_mask <= in_mask;
         if (w_ack) r_code <= f_enc(w_elig);
      end
   end
   always_ff @(posedge in_clk) begin
      if (!in_rst_n) r_state <= IDLE;
      else r_state <= w_next;
   end
   always_comb begin
      w_next = IDLE;
      case (r_state)
         IDLE:    w_next = (w_elig != 4'b0000) ? REQ : IDLE;
         REQ:     w_next = in_ack ? VEC : (w_elig != 4'b0000) ? REQ : IDLE;
         default: w_next = IDLE;
      endcase
   end
   // out_code is driven from registers only so the address decoder never sees an input path
   always_comb begin
      out_irq        = (r_state == REQ);
      out_code_valid = (r_state == VEC);
      out_code       = (r_state == VEC) ? r_code : f_enc(w_cand);
   end
   assign out_pending   = r_pending;
   assign out_inservice = r_inservice;
   assign out_mask      = r_mask;
endmodule

// File: tb/tb_irq_ctrl.sv
// tb_irq_ctrl: directed vector table plus randomized run against a behavioural model
module tb_irq_ctrl;
   logic       in_clk = 1'b0;
   logic       in_rst_n, in_ie, in_mask_we, in_ack, in_eret;
   logic [3:0] in_src, in_mask;
   logic       out_irq, out_code_valid;
   logic [1:0] out_code;
   logic [3:0] out_pending, out_inservice, out_mask;

   irq_ctrl dut (
      .in_clk(in_clk), .in_rst_n(in_rst_n), .in_src(in_src), .in_ie(in_ie),
      .in_mask_we(in_mask_we), .in_mask(in_mask), .in_ack(in_ack), .in_eret(in_eret),
      .out_irq(out_irq), .out_code(out_code), .out_code_valid(out_code_valid),
      .out_pending(out_pending), .out_inservice(out_inservice), .out_mask(out_mask)
   );

   always #5 in_clk = ~in_clk;

   typedef struct {
      logic       rst_n;
      logic [3:0] src;
      logic       ie, we;
      logic [3:0] mask;
      logic       ack, eret;
      logic       irq, valid;
      logic [1:0] code;
      logic [3:0] pend, ins, msk;
      logic       chk_code;
   } vec_t;

   vec_t tbl[$];
   int n_vec = 0;
   int n_err = 0;

   function automatic void v(input logic rst, input logic [3:0] src, input logic ie, input logic we,
                             input logic [3:0] mask, input logic ack, input logic eret,
                             input logic irq, input logic valid, input logic [1:0] code,
                             input logic [3:0] pend, input logic [3:0] ins, input logic [3:0] msk,
                             input logic chk);
      vec_t t;
      t.rst_n = rst; t.src = src; t.ie = ie; t.we = we; t.mask = mask; t.ack = ack; t.eret = eret;
      t.irq = irq; t.valid = valid; t.code = code; t.pend = pend; t.ins = ins; t.msk = msk;
      t.chk_code = chk;
      tbl.push_back(t);
   endfunction

   // Behavioural model: pending/in-service as bit sets, phase 0=idle 1=requesting 2=vector
   logic [3:0] m_pend, m_ins, m_mask, m_prev;
   logic [1:0] m_code;
   int         m_phase;

   function automatic int hi_of(input logic [3:0] x);
      for (int i = 3; i >= 0; i--) if (x[i]) return i;
      return -1;
   endfunction

   function automatic int cand_of(input logic gate);
      int h = hi_of(m_ins);
      for (int i = 3; i > h; i--) if (gate && m_pend[i] && !m_mask[i]) return i;
      return -1;
   endfunction

   task automatic model_step;
      int h, c;
      logic acc;
      logic [1:0] code;
      if (!in_rst_n) begin
         m_pend = 0; m_ins = 0; m_mask = 4'hF; m_prev = 0; m_code = 0; m_phase = 0;
      end else begin
         h = hi_of(m_ins);
         c = cand_of(in_ie);
         acc = (m_phase == 1) && in_ack;
         code = (c < 0) ? 2'd0 : c[1:0];
         if (in_eret && h >= 0) m_ins[h] = 1'b0;
         if (acc) begin
            m_ins[code] = 1'b1;
            m_pend[code] = 1'b0;
            m_code = code;
         end
         m_pend = m_pend | (in_src & ~m_prev);
         if (in_mask_we) m_mask = in_mask;
         m_prev = in_src;
         if (m_phase == 0) m_phase = (c >= 0) ? 1 : 0;
         else if (m_phase == 1) m_phase = acc ? 2 : ((c >= 0) ? 1 : 0);
         else m_phase = 0;
      end
   endtask

   task automatic check_model(input int cyc);
      int c;
      logic [1:0] ecode;
      logic bad;
      c = cand_of(1'b1);
      ecode = (m_phase == 2) ? m_code : ((c < 0) ? 2'd0 : c[1:0]);
      bad = (out_irq !== (m_phase == 1)) || (out_code_valid !== (m_phase == 2)) ||
            (out_pending !== m_pend) || (out_inservice !== m_ins) || (out_mask !== m_mask) ||
            ((in_ie || m_phase == 2) && out_code !== ecode);
      n_vec++;
      if (bad) begin
         n_err++;
         $display("FAIL rand cycle %0d: got irq=%b val=%b code=%0d pend=%b ins=%b mask=%b, want irq=%b val=%b code=%0d pend=%b ins=%b mask=%b",
                  cyc, out_irq, out_code_valid, out_code, out_pending, out_inservice, out_mask,
                  m_phase == 1, m_phase == 2, ecode, m_pend, m_ins, m_mask);
      end
   endtask

   initial begin
      //  rst src  ie we mask ack eret | irq val code pend  ins   msk  chk
      v(0, 4'h0, 1, 0, 4'h0, 0, 0,   0, 0, 0, 4'h0, 4'h0, 4'hF, 1); // reset
      v(1, 4'h0, 1, 1, 4'h0, 0, 0,   0, 0, 0, 4'h0, 4'h0, 4'h0, 1); // unmask all
      v(1, 4'h2, 1, 0, 4'h0, 0, 0,   0, 0, 1, 4'h2, 4'h0, 4'h0, 1); // single irq
      v(1, 4'h0, 1, 0, 4'h0, 0, 0,   1, 0, 1, 4'h2, 4'h0, 4'h0, 1);
      v(1, 4'h0, 1, 0, 4'h0, 1, 0,   0, 1, 1, 4'h0, 4'h2, 4'h0, 1);
      v(1, 4'h0, 1, 0, 4'h0, 0, 0,   0, 0, 0, 4'h0, 4'h2, 4'h0, 1);
      v(1, 4'h0, 1, 0, 4'h0, 0, 1,   0, 0, 0, 4'h0, 4'h0, 4'h0, 1);
      v(1, 4'h5, 1, 0, 4'h0, 0, 0,   0, 0, 2, 4'h5, 4'h0, 4'h0, 1); // priority
      v(1, 4'h5, 1, 0, 4'h0, 0, 0,   1, 0, 2, 4'h5, 4'h0, 4'h0, 1);
      v(1, 4'h0, 1, 0, 4'h0, 1, 0,   0, 1, 2, 4'h1, 4'h4, 4'h0, 1);
      v(1, 4'h0, 1, 0, 4'h0, 0, 0,   0, 0, 0, 4'h1, 4'h4, 4'h0, 1);
      v(1, 4'h0, 1, 0, 4'h0, 0, 0,   0, 0, 0, 4'h1, 4'h4, 4'h0, 1);
      v(1, 4'h0, 1, 0, 4'h0, 0, 1,   0, 0, 0, 4'h1, 4'h0, 4'h0, 1);
      v(1, 4'h0, 1, 0, 4'h0, 0, 0,   1, 0, 0, 4'h1, 4'h0, 4'h0, 1);
      v(1, 4'h0, 1, 0, 4'h0, 1, 0,   0, 1, 0, 4'h0, 4'h1, 4'h0, 1);
      v(1, 4'h0, 1, 0, 4'h0, 0, 1,   0, 0, 0, 4'h0, 4'h0, 4'h0, 1);
      v(1, 4'h2, 1, 0, 4'h0, 0, 0,   0, 0, 1, 4'h2, 4'h0, 4'h0, 1); // nesting
      v(1, 4'h0, 1, 0, 4'h0, 0, 0,   1, 0, 1, 4'h2, 4'h0, 4'h0, 1);
      v(1, 4'h0, 1, 0, 4'h0, 1, 0,   0, 1, 1, 4'h0, 4'h2, 4'h0, 1);
      v(1, 4'h8, 1, 0, 4'h0, 0, 0,   0, 0, 3, 4'h8, 4'h2, 4'h0, 1);
      v(1, 4'h1, 1, 0, 4'h0, 0, 0,   1, 0, 3, 4'h9, 4'h2, 4'h0, 1);
      v(1, 4'h0, 1, 0, 4'h0, 1, 0,   0, 1, 3, 4'h1, 4'hA, 4'h0, 1);
      v(1, 4'h0, 1, 0, 4'h0, 0, 0,   0, 0, 0, 4'h1, 4'hA, 4'h0, 1);
      v(1, 4'h0, 1, 0, 4'h0, 0, 1,   0, 0, 0, 4'h1, 4'h2, 4'h0, 1);
      v(1, 4'h0, 1, 0, 4'h0, 0, 0,   0, 0, 0, 4'h1, 4'h2, 4'h0, 1);
      v(1, 4'h0, 1, 0, 4'h0, 0, 1,   0, 0, 0, 4'h1, 4'h0, 4'h0, 1);
      v(1, 4'h0, 1, 0, 4'h0, 0, 0,   1, 0, 0, 4'h1, 4'h0, 4'h0, 1);
      v(1, 4'h0, 1, 0, 4'h0, 1, 0,   0, 1, 0, 4'h0, 4'h1, 4'h0, 1);
      v(1, 4'h0, 1, 0, 4'h0, 0, 1,   0, 0, 0, 4'h0, 4'h0, 4'h0, 1);
      v(1, 4'h0, 1, 1, 4'h4, 0, 0,   0, 0, 0, 4'h0, 4'h0, 4'h4, 1); // mask and enable
      v(1, 4'h4, 1, 0, 4'h4, 0, 0,   0, 0, 0, 4'h4, 4'h0, 4'h4, 1);
      v(1, 4'h0, 1, 0, 4'h4, 0, 0,   0, 0, 0, 4'h4, 4'h0, 4'h4, 1);
      v(1, 4'h0, 1, 1, 4'h0, 0, 0,   0, 0, 2, 4'h4, 4'h0, 4'h0, 1);
      v(1, 4'h0, 1, 0, 4'h0, 0, 0,   1, 0, 2, 4'h4, 4'h0, 4'h0, 1);
      v(1, 4'h0, 0, 0, 4'h0, 0, 0,   0, 0, 0, 4'h4, 4'h0, 4'h0, 0);
      v(1, 4'h0, 1, 0, 4'h0, 0, 0,   1, 0, 2, 4'h4, 4'h0, 4'h0, 1);
      v(1, 4'h0, 1, 0, 4'h0, 1, 0,   0, 1, 2, 4'h0, 4'h4, 4'h0, 1);
      v(1, 4'h0, 1, 0, 4'h0, 0, 1,   0, 0, 0, 4'h0, 4'h0, 4'h0, 1);
      v(1, 4'h0, 1, 0, 4'h0, 1, 0,   0, 0, 0, 4'h0, 4'h0, 4'h0, 1); // ack in idle
      v(1, 4'h0, 1, 0, 4'h0, 0, 1,   0, 0, 0, 4'h0, 4'h0, 4'h0, 1); // eret with nothing in service
      v(1, 4'h2, 1, 0, 4'h0, 0, 0,   0, 0, 1, 4'h2, 4'h0, 4'h0, 1);
      v(1, 4'h0, 1, 0, 4'h0, 0, 0,   1, 0, 1, 4'h2, 4'h0, 4'h0, 1);
      v(1, 4'h2, 1, 0, 4'h0, 1, 0,   0, 1, 1, 4'h2, 4'h2, 4'h0, 1); // edge with its own ack
      v(1, 4'h2, 1, 0, 4'h0, 1, 0,   0, 0, 0, 4'h2, 4'h2, 4'h0, 1); // ack in vec
      v(1, 4'h8, 1, 0, 4'h0, 0, 0,   0, 0, 3, 4'hA, 4'h2, 4'h0, 1);
      v(1, 4'h0, 1, 0, 4'h0, 0, 0,   1, 0, 3, 4'hA, 4'h2, 4'h0, 1);
      v(1, 4'h0, 1, 0, 4'h0, 1, 1,   0, 1, 3, 4'h2, 4'h8, 4'h0, 1); // ack with eret
      v(1, 4'h0, 1, 0, 4'h0, 0, 0,   0, 0, 0, 4'h2, 4'h8, 4'h0, 1);
      v(0, 4'h0, 1, 0, 4'h0, 0, 0,   0, 0, 0, 4'h0, 4'h0, 4'hF, 1);
      v(1, 4'h0, 1, 1, 4'h0, 0, 0,   0, 0, 0, 4'h0, 4'h0, 4'h0, 1);
      v(1, 4'h5, 1, 0, 4'h0, 0, 0,   0, 0, 2, 4'h5, 4'h0, 4'h0, 1);
      v(1, 4'h0, 1, 0, 4'h0, 0, 0,   1, 0, 2, 4'h5, 4'h0, 4'h0, 1);
      v(1, 4'h0, 1, 0, 4'h0, 1, 0,   0, 1, 2, 4'h1, 4'h4, 4'h0, 1);
      v(0, 4'h0, 1, 0, 4'h0, 0, 0,   0, 0, 0, 4'h0, 4'h0, 4'hF, 1); // reset mid-service
      v(1, 4'h1, 1, 0, 4'h0, 0, 0,   0, 0, 0, 4'h1, 4'h0, 4'hF, 1);

      foreach (tbl[k]) begin
         in_rst_n = tbl[k].rst_n; in_src = tbl[k].src; in_ie = tbl[k].ie; in_mask_we = tbl[k].we;
         in_mask = tbl[k].mask; in_ack = tbl[k].ack; in_eret = tbl[k].eret;
         @(posedge in_clk);
         @(negedge in_clk);
         n_vec++;
         if ({out_irq, out_code_valid, out_pending, out_inservice, out_mask} !==
             {tbl[k].irq, tbl[k].valid, tbl[k].pend, tbl[k].ins, tbl[k].msk} ||
             (tbl[k].chk_code && out_code !== tbl[k].code)) begin
            n_err++;
            $display("FAIL row %0d: got irq=%b val=%b code=%0d pend=%b ins=%b mask=%b, want irq=%b val=%b code=%0d pend=%b ins=%b mask=%b",
                     k, out_irq, out_code_valid, out_code, out_pending, out_inservice, out_mask,
                     tbl[k].irq, tbl[k].valid, tbl[k].code, tbl[k].pend, tbl[k].ins, tbl[k].msk);
         end
      end

      in_src = 4'h0;
      for (int i = 0; i < 3000; i++) begin
         in_rst_n   = !(i == 0 || $urandom_range(0, 299) == 0);
         if ($urandom_range(0, 3) == 0) in_src = 4'($urandom);
         in_ie      = ($urandom_range(0, 9) != 0);
         in_mask_we = ($urandom_range(0, 19) == 0);
         in_mask    = $urandom_range(0, 1) ? (4'($urandom) & 4'($urandom)) : 4'h0;
         in_ack     = ($urandom_range(0, 2) == 0);
         in_eret    = ($urandom_range(0, 7) == 0);
         @(posedge in_clk);
         model_step();
         @(negedge in_clk);
         check_model(i);
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end
endmodule
